int2float_pipe: RTL and testbench
=================================

Name: int2float_pipe

Overview:
- Parametrised, pipelined integer-to-minifloat converter.
- Successor to the fixed 11-bit to 7-bit combinational converter in the approximate-arithmetic benchmark set.
- Adds:
  - generic input and mantissa widths
  - an optional signed mode
  - per-transaction rounding selection (truncate or round-to-nearest-even) with overflow saturation
  - a 3-stage valid/ready pipeline, so the block can sit in streaming datapaths and serve as an accuracy-reference for approximate variants.

Parameters:
- IN_W, 11: integer input width (>= MAN_W+2).
- MAN_W, 4: stored mantissa width; leading one is implicit.
- SIGNED, 0: 1 = in_data is two's complement and out_data carries a sign MSB.
- EXP_W, derived = clog2(IN_W-SIGNED-MAN_W+1): exponent width; not overridable.
- OUT_W, derived = SIGNED+EXP_W+MAN_W.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  IN_W  integer operand.
- in_rnd  in  1  0 = truncate, 1 = round-to-nearest-even; travels with the word.
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts the result.
- out_data  out  OUT_W  {sign?, exponent, mantissa}.
- out_ovf  out  1  rounding overflowed the exponent range; result saturated.
- out_zero  out  1  input was zero.

Behaviour:
- Format. Let m = magnitude (|in_data| if SIGNED, else in_data); mag width MW = IN_W-SIGNED, or IN_W when SIGNED and in_data is the most negative value.
- Encoding, m < 2^MAN_W: exponent = 0, mantissa = m. Value is exact.
- Encoding, m >= 2^MAN_W: p = index of the leading one; exponent = p-MAN_W+1; mantissa = m[p-1 : p-MAN_W]; remainder R = m[p-MAN_W-1 : 0] (may be empty).
- Decoded value = (2^MAN_W + mant) << (exp-1).
- Rounding, in_rnd = 1, round-to-nearest-even on R:
  - R above half: increment mantissa.
  - R exactly half: increment only if mantissa LSB = 1.
  - Mantissa carry-out sets mantissa = 0 and exponent +1.
  - If the exponent then exceeds 2^EXP_W-1: saturate exponent and mantissa to all-ones, out_ovf = 1.
- Truncation, in_rnd = 0: R is discarded; out_ovf is always 0.
- Signed mode: sign bit = in_data MSB. Most negative input is handled exactly if the range allows, otherwise it saturates with out_ovf = 1. Zero always has sign 0.
- Pipeline stages:
  - S1: register operand, in_rnd, absolute value and zero flag.
  - S2: leading-one detect and normalising shift.
  - S3: round, pack, flags.
- Latency is exactly 3 cycles from acceptance to out_valid when out_ready is held high. Throughput is 1 word/cycle.
- Handshake:
  - adv = !out_valid | out_ready; in_ready = adv.
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - When adv = 0 all stages hold. Bubbles propagate as invalid stages.
  - Stalled outputs (out_data, flags) stay stable while out_valid & !out_ready.
- Per-stage valid bits: no word is dropped or duplicated. A word entering while a bubble leaves S3 is accepted normally.
- Reset:
  - All stage valids clear; out_valid = 0; out_data = 0; out_ovf = 0; out_zero = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset asserted mid-stream discards all in-flight words; nothing is emitted after reset for pre-reset inputs.
- in_data and in_rnd are ignored when in_valid = 0.

Test Plan:
- Defaults (IN_W=11, MAN_W=4, SIGNED=0), out_ready=1, stream 0, 15, 24 -> after 3 cycles: 0x00 with zero=1, then 0x0F, then 0x18 (exp 1, mant 1000), one per cycle.
- 1000 (p=9, R=01000), in_rnd=1 -> 0x6F, ovf=0. 49, in_rnd=1 (tie, even) -> 0x28. 51, in_rnd=1 (tie, odd) -> 0x2A. 51, in_rnd=0 -> 0x29.
- 2047, in_rnd=1 -> 0x7F, ovf=1. 2047, in_rnd=0 -> 0x7F, ovf=0.
- Backpressure: out_ready=0, send 5 words back-to-back:
  - in_ready drops after 3 accepted words.
  - out_data stays stable.
  - Raise out_ready: words emerge in order, one per cycle; all 5 delivered exactly once.
- Reset mid-stream: 2 words in flight, rst high for 1 cycle -> out_valid=0 and outputs 0 next cycle; no stale words emitted; the next accepted word emerges 3 cycles later.
- SIGNED=1, IN_W=12: -1000 -> sign 1, 0xEF pattern (1_110_1111). -2048 -> saturated 0xFF with ovf=1 under either in_rnd value.

Source files
------------

// File: rtl/int2float_pipe.sv
// ============================================================================
//  Module   : int2float_pipe
//  Purpose  : 3-stage valid/ready integer-to-minifloat converter with optional
//             signed mode, per-word truncate / round-to-nearest-even and saturation.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module int2float_pipe #(
    parameter int IN_W   = 11,
    parameter int MAN_W  = 4,
    parameter int SIGNED = 0,
    localparam int EXP_W = $clog2(IN_W - SIGNED - MAN_W + 1),
    localparam int OUT_W = SIGNED + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero
);

    // Two spare exponent bits hold the "leading one at MSB of most-negative" and carry cases.
    localparam int XW = EXP_W + 2;
    localparam int PW = $clog2(IN_W);
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    logic w_adv;

    logic             s1_vld_q, s1_vld_d, s1_sign_q, s1_sign_d;
    logic             s1_zero_q, s1_zero_d, s1_rnd_q, s1_rnd_d;
    logic [IN_W-1:0]  s1_mag_q, s1_mag_d;

    logic             s2_vld_q, s2_vld_d, s2_sign_q, s2_sign_d;
    logic             s2_zero_q, s2_zero_d, s2_rnd_q, s2_rnd_d;
    logic             s2_guard_q, s2_guard_d, s2_sticky_q, s2_sticky_d;
    logic [XW-1:0]    s2_exp_q, s2_exp_d;
    logic [MAN_W-1:0] s2_mant_q, s2_mant_d;

    logic             out_vld_q, out_vld_d, out_ovf_q, out_ovf_d;
    logic             out_zero_q, out_zero_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;

    logic [PW-1:0]    w_lead;
    logic [IN_W-1:0]  w_frac;
    logic             w_small;
    logic             w_inc;
    logic [MAN_W:0]   w_sum;
    logic [XW-1:0]    w_exp_r;

    assign w_adv     = !out_vld_q | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = out_vld_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_zero  = out_zero_q;

    // S1: capture operand and fold to magnitude (most negative maps to 2^(IN_W-1)).
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_sign_d = s1_sign_q;
        s1_zero_d = s1_zero_q;
        s1_rnd_d  = s1_rnd_q;
        s1_mag_d  = s1_mag_q;
        if (w_adv) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_rnd_d  = in_rnd;
                s1_zero_d = (in_data == '0);
                s1_sign_d = (SIGNED != 0) && in_data[IN_W-1];
                s1_mag_d  = s1_sign_d ? -in_data : in_data;
            end
        end
    end

    // S2: the normalising shift drops the implicit leading one off the top.
    always_comb begin
        w_lead = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (s1_mag_q[i]) w_lead = PW'(i);
        end
        w_small = (s1_mag_q[IN_W-1:MAN_W] == '0);
        w_frac  = IN_W'({s1_mag_q, 1'b0} << (PW'(IN_W - 1) - w_lead));
    end

    always_comb begin
        s2_vld_d    = s2_vld_q;
        s2_sign_d   = s2_sign_q;
        s2_zero_d   = s2_zero_q;
        s2_rnd_d    = s2_rnd_q;
        s2_exp_d    = s2_exp_q;
        s2_mant_d   = s2_mant_q;
        s2_guard_d  = s2_guard_q;
        s2_sticky_d = s2_sticky_q;
        if (w_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_sign_d = s1_sign_q;
                s2_zero_d = s1_zero_q;
                s2_rnd_d  = s1_rnd_q;
                if (w_small) begin
                    s2_exp_d    = '0;
                    s2_mant_d   = s1_mag_q[MAN_W-1:0];
                    s2_guard_d  = 1'b0;
                    s2_sticky_d = 1'b0;
                end else begin
                    s2_exp_d    = XW'(w_lead) - XW'(MAN_W - 1);
                    s2_mant_d   = w_frac[IN_W-1 -: MAN_W];
                    s2_guard_d  = w_frac[IN_W-1-MAN_W];
                    s2_sticky_d = |w_frac[IN_W-2-MAN_W:0];
                end
            end
        end
    end

    // S3: round-to-nearest-even, carry into exponent, saturate past the top code.
    always_comb begin
        w_inc   = s2_rnd_q & s2_guard_q & (s2_sticky_q | s2_mant_q[0]);
        w_sum   = {1'b0, s2_mant_q} + (MAN_W + 1)'(w_inc);
        w_exp_r = s2_exp_q + XW'(w_sum[MAN_W]);

        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        out_zero_d = out_zero_q;
        if (w_adv) begin
            out_vld_d = s2_vld_q;
            if (s2_vld_q) begin
                out_zero_d = s2_zero_q;
                if (w_exp_r > EXP_MAX) begin
                    out_ovf_d  = 1'b1;
                    out_data_d = OUT_W'({s2_sign_q, {(EXP_W + MAN_W){1'b1}}});
                end else begin
                    out_ovf_d  = 1'b0;
                    out_data_d = OUT_W'({s2_sign_q, w_exp_r[EXP_W-1:0], w_sum[MAN_W-1:0]});
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_rnd_q    <= 1'b0;
            s1_mag_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_rnd_q    <= 1'b0;
            s2_exp_q    <= '0;
            s2_mant_q   <= '0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_rnd_q    <= s1_rnd_d;
            s1_mag_q    <= s1_mag_d;
            s2_vld_q    <= s2_vld_d;
            s2_sign_q   <= s2_sign_d;
            s2_zero_q   <= s2_zero_d;
            s2_rnd_q    <= s2_rnd_d;
            s2_exp_q    <= s2_exp_d;
            s2_mant_q   <= s2_mant_d;
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_zero_q  <= out_zero_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_int2float_pipe.sv
// ============================================================================
//  Module   : tb_int2float_pipe
//  Purpose  : Scoreboard bench for int2float_pipe, unsigned default and signed 12-bit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_int2float_pipe;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        logic       zero;
        int         acc_cyc;
        bit         lat;
        bit         b2b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_ready = 1'b1;

    logic        in_valid_u = 1'b0, in_rnd_u = 1'b0, in_ready_u;
    logic [10:0] in_data_u = '0;
    logic        out_valid_u, out_ovf_u, out_zero_u;
    logic [6:0]  out_data_u;

    logic        in_valid_s = 1'b0, in_rnd_s = 1'b0, in_ready_s;
    logic [11:0] in_data_s = '0;
    logic        out_valid_s, out_ovf_s, out_zero_s;
    logic [7:0]  out_data_s;

    exp_t q_u[$];
    exp_t q_s[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_u   = 0;
    int   last_s   = 0;
    int   n_out_u  = 0;
    bit   lat_en   = 1'b1;

    int2float_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid_u), .in_ready(in_ready_u),
        .in_data(in_data_u), .in_rnd(in_rnd_u), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_data(out_data_u), .out_ovf(out_ovf_u),
        .out_zero(out_zero_u)
    );

    int2float_pipe #(.IN_W(12), .MAN_W(4), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .in_data(in_data_s), .in_rnd(in_rnd_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_ovf(out_ovf_s),
        .out_zero(out_zero_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e, input logic [7:0] d,
                             input logic o, input logic z, input int last);
        chk({tag, "_data"}, int'(d), int'(e.data));
        chk({tag, "_ovf"},  int'(o), int'(e.ovf));
        chk({tag, "_zero"}, int'(z), int'(e.zero));
        if (e.lat) chk({tag, "_latency"}, cyc - e.acc_cyc, 3);
        if (e.b2b) chk({tag, "_back_to_back"}, cyc - last, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid_u && out_ready) begin
            if (q_u.size() == 0) begin
                chk("u_unexpected_output", int'(out_data_u), -1);
            end else begin
                check_out("u", q_u.pop_front(), {1'b0, out_data_u}, out_ovf_u, out_zero_u, last_u);
            end
            last_u = cyc;
            n_out_u++;
        end
        if (!rst && out_valid_s && out_ready) begin
            if (q_s.size() == 0) begin
                chk("s_unexpected_output", int'(out_data_s), -1);
            end else begin
                check_out("s", q_s.pop_front(), out_data_s, out_ovf_s, out_zero_s, last_s);
            end
            last_s = cyc;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input bit sel, input logic [11:0] d, input logic r,
                        input logic [7:0] ed, input logic eo, input logic ez, input bit b2b);
        exp_t e;
        bit   acc;
        if (sel) begin
            in_valid_s = 1'b1; in_data_s = d; in_rnd_s = r;
        end else begin
            in_valid_u = 1'b1; in_data_u = d[10:0]; in_rnd_u = r;
        end
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = sel ? in_ready_s : in_ready_u;
            e.acc_cyc = cyc;
            @(posedge clk);
        end
        e.data = ed; e.ovf = eo; e.zero = ez; e.lat = lat_en; e.b2b = b2b;
        if (acc) begin
            if (sel) q_s.push_back(e); else q_u.push_back(e);
        end else begin
            chk("accept_timeout", 0, 1);
        end
        #1;
        in_valid_u = 1'b0;
        in_valid_s = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && (q_u.size() != 0 || q_s.size() != 0); k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid_u), 0);
        chk("rst_out_data",  int'(out_data_u), 0);
        chk("rst_out_ovf",   int'(out_ovf_u), 0);
        chk("rst_out_zero",  int'(out_zero_u), 0);
        chk("rst_s_out_valid", int'(out_valid_s), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready",   int'(in_ready_u), 1);
        chk("post_rst_in_ready_s", int'(in_ready_s), 1);
        @(posedge clk); #1;

        // Streaming and rounding vectors on the unsigned default instance.
        send(0, 12'd0,    0, 8'h00, 0, 1, 0);
        send(0, 12'd15,   0, 8'h0F, 0, 0, 1);
        send(0, 12'd24,   0, 8'h18, 0, 0, 1);
        send(0, 12'd1000, 1, 8'h6F, 0, 0, 0);
        send(0, 12'd49,   1, 8'h28, 0, 0, 0);
        send(0, 12'd51,   1, 8'h2A, 0, 0, 0);
        send(0, 12'd51,   0, 8'h29, 0, 0, 0);
        send(0, 12'd2047, 1, 8'h7F, 1, 0, 0);
        send(0, 12'd2047, 0, 8'h7F, 0, 0, 0);
        send(0, 12'd16,   1, 8'h10, 0, 0, 0);
        send(0, 12'd31,   1, 8'h1F, 0, 0, 0);
        send(0, 12'd33,   1, 8'h20, 0, 0, 0);
        send(0, 12'd35,   1, 8'h22, 0, 0, 0);
        send(0, 12'd63,   1, 8'h30, 0, 0, 0);
        send(0, 12'd1024, 0, 8'h70, 0, 0, 0);
        send(0, 12'd1983, 1, 8'h7F, 0, 0, 0);
        send(0, 12'd2046, 1, 8'h7F, 1, 0, 0);
        drain();

        // Backpressure: three words fill the pipe, the fourth waits.
        @(posedge clk); #1;
        out_ready = 1'b0;
        lat_en = 1'b0;
        n0 = n_out_u;
        send(0, 12'd100, 0, 8'h39, 0, 0, 0);
        send(0, 12'd200, 0, 8'h49, 0, 0, 1);
        send(0, 12'd300, 0, 8'h52, 0, 0, 1);
        in_valid_u = 1'b1; in_data_u = 11'd400; in_rnd_u = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_in_ready",  int'(in_ready_u), 0);
            chk("stall_out_valid", int'(out_valid_u), 1);
            chk("stall_out_data",  int'(out_data_u), 'h39);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        lat_en = 1'b1;
        send(0, 12'd400, 0, 8'h59, 0, 0, 1);
        send(0, 12'd500, 0, 8'h5F, 0, 0, 1);
        drain();
        chk("bp_delivered", n_out_u - n0, 5);

        // Reset with two words in flight.
        send(0, 12'd100, 0, 8'h39, 0, 0, 0);
        send(0, 12'd200, 0, 8'h49, 0, 0, 0);
        rst = 1'b1;
        q_u.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", int'(out_valid_u), 0);
        chk("mid_rst_out_data",  int'(out_data_u), 0);
        chk("mid_rst_out_ovf",   int'(out_ovf_u), 0);
        chk("mid_rst_out_zero",  int'(out_zero_u), 0);
        chk("mid_rst_in_ready",  int'(in_ready_u), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_stale_word", int'(out_valid_u), 0);
        end
        @(posedge clk); #1;
        send(0, 12'd24, 0, 8'h18, 0, 0, 0);
        drain();

        // Signed 12-bit instance.
        send(1, 12'hC18, 0, 8'hEF, 0, 0, 0);
        send(1, 12'hC18, 1, 8'hEF, 0, 0, 1);
        send(1, 12'h800, 0, 8'hFF, 1, 0, 1);
        send(1, 12'h800, 1, 8'hFF, 1, 0, 1);
        send(1, 12'h000, 1, 8'h00, 0, 1, 1);
        send(1, 12'h3E8, 1, 8'h6F, 0, 0, 1);
        send(1, 12'hFFF, 0, 8'h81, 0, 0, 1);
        send(1, 12'h801, 1, 8'hFF, 1, 0, 1);
        send(1, 12'h801, 0, 8'hFF, 0, 0, 1);
        send(1, 12'h7FF, 0, 8'h7F, 0, 0, 1);
        drain();

        chk("u_queue_empty", q_u.size(), 0);
        chk("s_queue_empty", q_s.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
